// File: rtl/dcache_pkg.sv
// Shared types and helpers for the L1 data-cache controller and its line store.
package dcache_pkg;
  typedef enum logic [2:0] {S_IDLE, S_RREQ, S_REFILL, S_WREQ, S_WDONE} dcache_state_t;

  function automatic int OFF_W(input int line_words);
    return $clog2(line_words);
  endfunction

  function automatic int IDX_W(input int sets);
    return $clog2(sets);
  endfunction

  // Tag is whatever remains above offset, index and the 2 byte-select bits.
  function automatic int TAG_W(input int aw, input int sets, input int line_words);
    return aw - IDX_W(sets) - OFF_W(line_words) - 2;
  endfunction

  function automatic logic [31:0] byte_merge(input logic [31:0] old_w,
                                             input logic [31:0] new_w,
                                             input logic [3:0]  be);
    logic [31:0] r;
    r = old_w;
    for (int b = 0; b < 4; b++)
      if (be[b]) r[8*b +: 8] = new_w[8*b +: 8];
    return r;
  endfunction
endpackage

// File: rtl/dcache_line_store.sv
// Valid/tag/data arrays: combinational read, byte-enabled word write, tag+valid set.
module dcache_line_store
  import dcache_pkg::*;
#(
  parameter int SETS       = 64,
  parameter int LINE_WORDS = 4,
  parameter int TAG_BITS   = 24,
  localparam int IW = IDX_W(SETS),
  localparam int OW = OFF_W(LINE_WORDS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [IW-1:0]       rd_idx,
  input  logic [OW-1:0]       rd_off,
  output logic                rd_valid,
  output logic [TAG_BITS-1:0] rd_tag,
  output logic [31:0]         rd_word,
  input  logic                wr_en,
  input  logic [IW-1:0]       wr_idx,
  input  logic [OW-1:0]       wr_off,
  input  logic [3:0]          wr_be,
  input  logic [31:0]         wr_data,
  input  logic                tv_en,
  input  logic [IW-1:0]       tv_idx,
  input  logic [TAG_BITS-1:0] tv_tag
);
  logic [SETS-1:0]             valid_q, valid_d;
  logic [TAG_BITS-1:0]         tag_q  [SETS];
  logic [LINE_WORDS-1:0][31:0] data_q [SETS];

  always_comb begin
    valid_d = valid_q;
    if (tv_en) valid_d[tv_idx] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) valid_q <= '0;
    else        valid_q <= valid_d;

  // Tags and data carry no reset; a line is only trusted through its valid bit.
  always_ff @(posedge clk) begin
    if (tv_en) tag_q[tv_idx] <= tv_tag;
    if (wr_en) data_q[wr_idx][wr_off] <= byte_merge(data_q[wr_idx][wr_off], wr_data, wr_be);
  end

  assign rd_valid = valid_q[rd_idx];
  assign rd_tag   = tag_q[rd_idx];
  assign rd_word  = data_q[rd_idx][rd_off];
endmodule

// File: rtl/l1_dcache_ctrl.sv
// Direct-mapped write-through, no-write-allocate L1 D-cache controller for the MEM stage.
module l1_dcache_ctrl
  import dcache_pkg::*;
#(
  parameter int SETS       = 64,
  parameter int LINE_WORDS = 4,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  mem_read,
  input  logic                  mem_write,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [31:0]           wdata,
  input  logic [3:0]            byte_en,
  output logic [31:0]           rdata,
  output logic                  l1_miss,
  output logic                  cache_busy,
  output logic                  mem_stall,
  output logic                  l2_req_valid,
  input  logic                  l2_req_ready,
  output logic                  l2_req_we,
  output logic [ADDR_WIDTH-1:0] l2_req_addr,
  output logic [31:0]           l2_req_wdata,
  output logic [3:0]            l2_req_be,
  input  logic                  l2_resp_valid,
  input  logic [31:0]           l2_resp_data
);
  localparam int OW = OFF_W(LINE_WORDS);
  localparam int IW = IDX_W(SETS);
  localparam int TW = TAG_W(ADDR_WIDTH, SETS, LINE_WORDS);

  dcache_state_t         state_q, state_d;
  logic [OW-1:0]         cnt_q, cnt_d;
  logic                  req_valid_q, req_valid_d, req_we_q, req_we_d;
  logic [ADDR_WIDTH-1:0] req_addr_q, req_addr_d;
  logic [31:0]           req_wdata_q, req_wdata_d;
  logic [3:0]            req_be_q, req_be_d;

  logic [ADDR_WIDTH-1:0] lk_addr;
  logic [OW-1:0]         lk_off, wr_off;
  logic [IW-1:0]         lk_idx;
  logic [TW-1:0]         lk_tag, rd_tag;
  logic                  rd_valid, hit, wr_en, tv_en;
  logic [31:0]           rd_word, wr_data;
  logic [3:0]            wr_be;
  logic                  unused_bits;

  // The latched request address doubles as the lookup/fill address once we leave IDLE.
  assign lk_addr     = (state_q == S_IDLE) ? addr : req_addr_q;
  assign lk_off      = lk_addr[2 +: OW];
  assign lk_idx      = lk_addr[2+OW +: IW];
  assign lk_tag      = lk_addr[ADDR_WIDTH-1 -: TW];
  assign hit         = rd_valid && (rd_tag == lk_tag);
  assign unused_bits = ^lk_addr[1:0];

  dcache_line_store #(.SETS(SETS), .LINE_WORDS(LINE_WORDS), .TAG_BITS(TW)) u_store (
    .clk     (clk),
    .rst_n   (rst_n),
    .rd_idx  (lk_idx),
    .rd_off  (lk_off),
    .rd_valid(rd_valid),
    .rd_tag  (rd_tag),
    .rd_word (rd_word),
    .wr_en   (wr_en),
    .wr_idx  (req_addr_q[2+OW +: IW]),
    .wr_off  (wr_off),
    .wr_be   (wr_be),
    .wr_data (wr_data),
    .tv_en   (tv_en),
    .tv_idx  (req_addr_q[2+OW +: IW]),
    .tv_tag  (req_addr_q[ADDR_WIDTH-1 -: TW])
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    req_valid_d = req_valid_q;
    req_we_d    = req_we_q;
    req_addr_d  = req_addr_q;
    req_wdata_d = req_wdata_q;
    req_be_d    = req_be_q;
    wr_en       = 1'b0;
    wr_off      = cnt_q;
    wr_be       = 4'hF;
    wr_data     = l2_resp_data;
    tv_en       = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        // A read wins over a simultaneous write; the write is dropped.
        if (mem_read) begin
          if (!hit) begin
            state_d     = S_RREQ;
            req_valid_d = 1'b1;
            req_we_d    = 1'b0;
            req_addr_d  = {addr[ADDR_WIDTH-1:OW+2], {(OW+2){1'b0}}};
          end
        end else if (mem_write) begin
          state_d     = S_WREQ;
          req_valid_d = 1'b1;
          req_we_d    = 1'b1;
          req_addr_d  = {addr[ADDR_WIDTH-1:2], 2'b00};
          req_wdata_d = wdata;
          req_be_d    = byte_en;
        end
      end
      S_RREQ: if (l2_req_ready) begin
        req_valid_d = 1'b0;
        cnt_d       = '0;
        state_d     = S_REFILL;
      end
      S_REFILL: if (l2_resp_valid) begin
        wr_en = 1'b1;
        cnt_d = cnt_q + 1'b1;
        if (&cnt_q) begin
          tv_en   = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_WREQ: if (l2_req_ready) begin
        req_valid_d = 1'b0;
        state_d     = S_WDONE;
        if (hit) begin
          wr_en   = 1'b1;
          wr_off  = lk_off;
          wr_be   = req_be_q;
          wr_data = req_wdata_q;
        end
      end
      S_WDONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      req_valid_q <= 1'b0;
      req_we_q    <= 1'b0;
      req_addr_q  <= '0;
      req_wdata_q <= '0;
      req_be_q    <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      req_valid_q <= req_valid_d;
      req_we_q    <= req_we_d;
      req_addr_q  <= req_addr_d;
      req_wdata_q <= req_wdata_d;
      req_be_q    <= req_be_d;
    end

  assign l2_req_valid = req_valid_q;
  assign l2_req_we    = req_we_q;
  assign l2_req_addr  = req_addr_q;
  assign l2_req_wdata = req_wdata_q;
  assign l2_req_be    = req_be_q;
  assign cache_busy   = (state_q == S_RREQ) || (state_q == S_REFILL);
  assign mem_stall    = ((state_q == S_IDLE) && mem_write) || (state_q == S_WREQ);
  assign l1_miss      = (state_q == S_IDLE) && mem_read && !hit;
  assign rdata        = ((state_q == S_IDLE) && mem_read && hit) ? rd_word : 32'h0;
endmodule

// File: tb/tb_l1_dcache_ctrl.sv
// Randomized bench for l1_dcache_ctrl; the bench also plays the L2 side.
module tb_l1_dcache_ctrl;
  localparam int SETS = 64, LW = 4, AW = 32, LINE_B = LW * 4;

  logic          clk = 1'b0, rst_n = 1'b0;
  logic          mem_read = 1'b0, mem_write = 1'b0;
  logic [AW-1:0] addr = '0;
  logic [31:0]   wdata = '0;
  logic [3:0]    byte_en = '0;
  logic [31:0]   rdata;
  logic          l1_miss, cache_busy, mem_stall;
  logic          l2_req_valid, l2_req_we;
  logic          l2_req_ready = 1'b0;
  logic [AW-1:0] l2_req_addr;
  logic [31:0]   l2_req_wdata;
  logic [3:0]    l2_req_be;
  logic          l2_resp_valid = 1'b0;
  logic [31:0]   l2_resp_data = '0;

  always #5 clk = ~clk;

  l1_dcache_ctrl #(.SETS(SETS), .LINE_WORDS(LW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n), .mem_read(mem_read), .mem_write(mem_write),
    .addr(addr), .wdata(wdata), .byte_en(byte_en), .rdata(rdata),
    .l1_miss(l1_miss), .cache_busy(cache_busy), .mem_stall(mem_stall),
    .l2_req_valid(l2_req_valid), .l2_req_ready(l2_req_ready), .l2_req_we(l2_req_we),
    .l2_req_addr(l2_req_addr), .l2_req_wdata(l2_req_wdata), .l2_req_be(l2_req_be),
    .l2_resp_valid(l2_resp_valid), .l2_resp_data(l2_resp_data)
  );

  always @(posedge clk)
    if (rst_n) assert (!(mem_read && mem_write)) else $error("illegal simultaneous read and write");

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Reference: per-set valid/tag/words, plus a backing L2 image.
  bit          mvalid [SETS];
  int unsigned mtag   [SETS];
  logic [31:0] mline  [SETS][LW];
  logic [31:0] l2mem  [int unsigned];

  function automatic int unsigned m_idx(input int unsigned a); return (a / LINE_B) % SETS; endfunction
  function automatic int unsigned m_tag(input int unsigned a); return a / (LINE_B * SETS); endfunction
  function automatic int unsigned m_wrd(input int unsigned a); return (a / 4) % LW; endfunction
  function automatic bit m_hit(input int unsigned a); return mvalid[m_idx(a)] && mtag[m_idx(a)] == m_tag(a); endfunction

  function automatic logic [31:0] l2_rd(input int unsigned wa);
    if (l2mem.exists(wa)) return l2mem[wa];
    return (wa * 32'h9E3779B1) ^ 32'h5A5A0000;
  endfunction

  function automatic logic [31:0] mrg(input logic [31:0] o, input logic [31:0] n, input logic [3:0] be);
    logic [31:0] mask;
    mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    return (o & ~mask) | (n & mask);
  endfunction

  task automatic rd(input logic [31:0] a, input int rdy_dly, input int gap);
    int unsigned i0 = m_idx(a);
    int unsigned base = a & ~(LINE_B - 1);
    int busy_cyc;
    @(negedge clk); mem_read = 1'b1; mem_write = 1'b0; addr = a; #1;
    if (m_hit(a)) begin
      chk("rd_hit_nomiss", l1_miss, 0);
      chk("rd_hit_data", rdata, mline[i0][m_wrd(a)]);
      return;
    end
    chk("rd_miss", l1_miss, 1);
    chk("rd_miss_nobusy", cache_busy, 0);
    busy_cyc = int'(l1_miss);
    for (int i = 0; i <= rdy_dly; i++) begin
      @(negedge clk); l2_req_ready = (i == rdy_dly); #1;
      busy_cyc += int'(cache_busy);
      chk("rreq_valid", l2_req_valid, 1);
      chk("rreq_we", l2_req_we, 0);
      chk("rreq_addr", l2_req_addr, base);
      chk("rreq_busy", cache_busy, 1);
    end
    for (int w = 0; w < LW; w++) begin
      for (int g = 0; g < gap; g++) begin
        @(negedge clk); l2_req_ready = 1'b0; l2_resp_valid = 1'b0; #1;
        busy_cyc += int'(cache_busy);
        chk("gap_busy", cache_busy, 1);
      end
      @(negedge clk); l2_req_ready = 1'b0; l2_resp_valid = 1'b1; l2_resp_data = l2_rd(base + 4 * w); #1;
      busy_cyc += int'(cache_busy);
      chk("beat_busy", cache_busy, 1);
      chk("beat_reqdrop", l2_req_valid, 0);
    end
    @(negedge clk); l2_resp_valid = 1'b0; #1;
    mvalid[i0] = 1'b1;
    mtag[i0]   = m_tag(a);
    for (int w = 0; w < LW; w++) mline[i0][w] = l2_rd(base + 4 * w);
    chk("fill_busy", cache_busy, 0);
    chk("fill_nomiss", l1_miss, 0);
    chk("fill_data", rdata, mline[i0][m_wrd(a)]);
    chk("miss_stall_cycles", busy_cyc, LW + 2 + rdy_dly + gap * LW);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be, input int rdy_dly);
    int unsigned wa = a & ~32'h3;
    @(negedge clk); mem_read = 1'b0; mem_write = 1'b1; addr = a; wdata = d; byte_en = be; #1;
    chk("st_stall0", mem_stall, 1);
    chk("st_nomiss", l1_miss, 0);
    for (int i = 0; i <= rdy_dly; i++) begin
      @(negedge clk); l2_req_ready = (i == rdy_dly); #1;
      chk("wreq_valid", l2_req_valid, 1);
      chk("wreq_we", l2_req_we, 1);
      chk("wreq_addr", l2_req_addr, wa);
      chk("wreq_wdata", l2_req_wdata, d);
      chk("wreq_be", l2_req_be, be);
      chk("wreq_stall", mem_stall, 1);
      chk("wreq_nobusy", cache_busy, 0);
    end
    @(negedge clk); l2_req_ready = 1'b0; #1;
    chk("wdone_stall", mem_stall, 0);
    chk("wdone_reqdrop", l2_req_valid, 0);
    l2mem[wa] = mrg(l2_rd(wa), d, be);
    if (m_hit(a)) mline[m_idx(a)][m_wrd(a)] = mrg(mline[m_idx(a)][m_wrd(a)], d, be);
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_valid"}, l2_req_valid, 0);
    chk({tag, "_we"}, l2_req_we, 0);
    chk({tag, "_addr"}, l2_req_addr, 0);
    chk({tag, "_wdata"}, l2_req_wdata, 0);
    chk({tag, "_be"}, l2_req_be, 0);
    chk({tag, "_busy"}, cache_busy, 0);
    chk({tag, "_stall"}, mem_stall, 0);
    chk({tag, "_miss"}, l1_miss, 0);
    chk({tag, "_rdata"}, rdata, 0);
  endtask

  initial begin
    for (int s = 0; s < SETS; s++) mvalid[s] = 1'b0;
    l2mem[32'h100] = 32'hA0A0A0A0;
    l2mem[32'h104] = 32'h11223344;
    l2mem[32'h108] = 32'hA2A2A2A2;
    l2mem[32'h10C] = 32'hA3A3A3A3;

    repeat (3) @(negedge clk);
    chk_reset_outs("reset");
    rst_n = 1'b1;

    // Cold miss best case, then a same-line hit.
    rd(32'h100, 0, 0);
    chk("cold_A0", rdata, 32'hA0A0A0A0);
    rd(32'h104, 0, 0);
    chk("hit_A1", rdata, 32'h11223344);

    // Byte-merge into a hit line.
    wr(32'h104, 32'hDEADBEEF, 4'b0011, 0);
    rd(32'h104, 0, 0);
    chk("merge_word", rdata, 32'h1122BEEF);

    // Store miss: no allocation, so the read that follows must miss.
    wr(32'h2000, 32'hCAFEF00D, 4'b1111, 1);
    rd(32'h2000, 0, 0);

    // Slow L2: ready late, gaps between beats.
    rd(32'h40C, 3, 2);

    // Reset in the middle of a refill; late beats must not install anything.
    @(negedge clk); mem_read = 1'b1; mem_write = 1'b0; addr = 32'h308; #1;
    chk("mid_rst_miss", l1_miss, !m_hit(32'h308));
    @(negedge clk); l2_req_ready = 1'b1;
    for (int w = 0; w < 3; w++) begin
      @(negedge clk); l2_req_ready = 1'b0; l2_resp_valid = 1'b1; l2_resp_data = l2_rd(32'h300 + 4 * w);
    end
    @(negedge clk); l2_resp_valid = 1'b0; rst_n = 1'b0; mem_read = 1'b0; #1;
    chk_reset_outs("mid_rst");
    for (int s = 0; s < SETS; s++) mvalid[s] = 1'b0;
    @(negedge clk); rst_n = 1'b1; l2_resp_valid = 1'b1; l2_resp_data = l2_rd(32'h30C); #1;
    chk("late_beat_nobusy", cache_busy, 0);
    @(negedge clk); l2_resp_valid = 1'b0;
    rd(32'h308, 0, 0);
    rd(32'h100, 0, 1);

    // Conflict eviction on the same index.
    rd(32'h100 + SETS * LINE_B, 1, 0);
    rd(32'h100, 0, 0);

    // Random mix over a small set of tags/indices to force hits, misses and conflicts.
    for (int n = 0; n < 300; n++) begin
      logic [31:0] a;
      a = ($urandom_range(0, 3) * SETS * LINE_B) + ($urandom_range(0, 3) * LINE_B)
        + ($urandom_range(0, LW - 1) * 4) + $urandom_range(0, 3);
      if ($urandom_range(0, 9) < 7) rd(a, $urandom_range(0, 2), $urandom_range(0, 2));
      else wr(a, $urandom, 4'($urandom_range(1, 15)), $urandom_range(0, 2));
    end

    @(negedge clk); mem_read = 1'b0; mem_write = 1'b0; #1;
    chk("final_idle_stall", mem_stall, 0);
    chk("final_idle_busy", cache_busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
